// File: rtl/useq_uart_bridge_if.sv
// Byte-wide handshake between the UART bridge and the useq host/outbound FIFOs.
// master = bridge side, slave = FIFO side.
interface useq_uart_bridge_if;
    logic [7:0] fifo_in;
    logic       write_fifo;
    logic       fifo_full;
    logic [7:0] fifo_out;
    logic       read_fifo;
    logic       fifo_empty;

    modport master (
        output fifo_in,
        output write_fifo,
        output read_fifo,
        input  fifo_full,
        input  fifo_out,
        input  fifo_empty
    );

    modport slave (
        input  fifo_in,
        input  write_fifo,
        input  read_fifo,
        output fifo_full,
        output fifo_out,
        output fifo_empty
    );
endinterface

// File: rtl/useq_uart_bridge.sv
// 8N1 UART <-> useq FIFO bridge with a 1-entry RX holding register.
// Define USEQ_BRIDGE_OVERRUN_EN to enable the sticky rx_overrun flag.
module useq_uart_bridge #(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rx,
    output logic               uart_tx,
    output logic               tx_busy,
    output logic               rx_overrun,
    useq_uart_bridge_if.master fifo
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // RX synchronizer; rx_prev gives the falling-edge reference
    logic rx_meta, rx_sync, rx_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    state_t           rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_stop_ok_c;

    assign rx_stop_ok_c = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST) && rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync) rx_state <= ST_START;
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    // Holding register; a byte finishing while the slot is occupied is dropped
    logic       hold_valid;
    logic [7:0] hold_byte;
    logic [7:0] fifo_in_q;
    logic       write_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_byte  <= '0;
            fifo_in_q  <= '0;
            write_q    <= 1'b0;
        end else begin
            write_q <= 1'b0;
            if (hold_valid && !fifo.fifo_full) begin
                write_q    <= 1'b1;
                fifo_in_q  <= hold_byte;
                hold_valid <= 1'b0;
            end
            if (rx_stop_ok_c && !hold_valid) begin
                hold_byte  <= rx_shift;
                hold_valid <= 1'b1;
            end
        end
    end

`ifdef USEQ_BRIDGE_OVERRUN_EN
    logic overrun_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else if (rx_stop_ok_c && hold_valid) overrun_q <= 1'b1;
    end
    assign rx_overrun = overrun_q;
`else
    assign rx_overrun = 1'b0;
`endif

    state_t           tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_q;
    logic             busy_q;
    logic             read_q;

    // TX: pop and load in IDLE, then START/DATA/STOP each CLKS_PER_BIT long
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            read_q <= 1'b0;
            case (tx_state)
                ST_IDLE: begin
                    tx_cnt <= '0;
                    if (!fifo.fifo_empty) begin
                        read_q   <= 1'b1;
                        tx_shift <= fifo.fifo_out;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_q     <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            tx_q     <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_q     <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        busy_q   <= 1'b0;
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    assign uart_tx         = tx_q;
    assign tx_busy         = busy_q;
    assign fifo.fifo_in    = fifo_in_q;
    assign fifo.write_fifo = write_q;
    assign fifo.read_fifo  = read_q;
endmodule

// File: tb/tb_useq_uart_bridge.sv
// Scoreboard bench for useq_uart_bridge: UART line model on RX, frame decoder on TX,
// FIFO models on both sides; expectations queued at stimulus time.
`timescale 1ns/1ps
module tb_useq_uart_bridge;
    localparam int C = 8;
`ifdef USEQ_BRIDGE_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic uart_rx;
    logic uart_tx;
    logic tx_busy;
    logic rx_overrun;

    useq_uart_bridge_if bus ();

    useq_uart_bridge #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .rx_overrun(rx_overrun),
        .fifo      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_push_cyc = -1;
    int rx_start_cyc = 0;
    bit exp_overrun = 1'b0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic [7:0] tx_src[$];
    int read_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ovr();
        return exp_overrun & OVR_EN;
    endfunction

    // Host-side FIFO models and push monitor
    always @(negedge clk) begin
        cyc++;
        if (rst_n === 1'b1) begin
            if (bus.write_fifo === 1'b1) begin
                check("push_while_full", 32'(bus.fifo_full), 32'd0);
                if (rx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_push: got 0x%0h expected none", bus.fifo_in);
                end else begin
                    check("rx_byte", 32'(bus.fifo_in), 32'(rx_exp.pop_front()));
                end
                last_push_cyc = cyc;
            end
            if (bus.read_fifo === 1'b1) begin
                check("read_while_empty", 32'(bus.fifo_empty), 32'd0);
                if (tx_src.size() > 0) void'(tx_src.pop_front());
                read_cyc.push_back(cyc);
            end
        end
        bus.fifo_empty = (tx_src.size() == 0);
        bus.fifo_out   = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
    end

    // TX line decoder: mid-bit sampling from the start-bit falling edge
    int dec_t = -1;
    logic tx_prev = 1'b1;
    logic [9:0] dec_bits = '0;
    bit dec_busy_ok = 1'b1;
    always @(negedge clk) begin
        logic [7:0] eb;
        if (rst_n !== 1'b1) begin
            if (dec_t >= 0 && tx_exp.size() > 0) void'(tx_exp.pop_front());
            dec_t = -1;
            tx_prev = 1'b1;
        end else begin
            if (dec_t < 0) begin
                if (tx_prev && !uart_tx) begin
                    dec_t = 0;
                    dec_busy_ok = 1'b1;
                end
            end else begin
                dec_t++;
            end
            if (dec_t >= 0) begin
                if ((dec_t % C) == C / 2 && dec_t < 10 * C) begin
                    dec_bits[dec_t / C] = uart_tx;
                    if (tx_busy !== 1'b1) dec_busy_ok = 1'b0;
                end
                if (dec_t == 10 * C) begin
                    if (tx_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tx_frame: got 0x%0h expected none", dec_bits);
                    end else begin
                        eb = tx_exp.pop_front();
                        check("tx_frame", 32'(dec_bits), 32'({1'b1, eb, 1'b0}));
                    end
                    check("tx_busy_in_frame", 32'(dec_busy_ok), 32'd1);
                    check("tx_idle_after_stop", 32'({tx_busy, uart_tx}), 32'b01);
                    dec_t = -1;
                end
            end
            tx_prev = uart_tx;
        end
    end

    // Drive one 8N1 frame; expectation is decided before the receiver's stop sample
    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        rx_start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            if (i == 9) begin
                repeat (C / 2) @(negedge clk);
                if (stop_ok) begin
                    if (rx_exp.size() > 0) exp_overrun = 1'b1;
                    else rx_exp.push_back(b);
                end
                repeat (C - C / 2) @(negedge clk);
            end else begin
                repeat (C) @(negedge clk);
            end
        end
        uart_rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((rx_exp.size() > 0 || tx_exp.size() > 0 || tx_src.size() > 0 || dec_t >= 0)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 3000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int saved;
        int lat;
        logic [7:0] tb_byte;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        bus.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_write_fifo", 32'(bus.write_fifo), 32'd0);
        check("rst_read_fifo", 32'(bus.read_fifo), 32'd0);
        check("rst_fifo_in", 32'(bus.fifo_in), 32'd0);
        check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte receive with latency window
        send_rx(8'hA5, 1'b1);
        repeat (8) @(negedge clk);
        lat = last_push_cyc - rx_start_cyc;
        check("rx_a5_pushed", 32'(rx_exp.size()), 32'd0);
        check("rx_latency_window", 32'((lat >= 9 * C + C / 2 - 1) && (lat <= 10 * C + 3)), 32'd1);

        // Start glitch must not produce a byte; receiver recovers
        saved = last_push_cyc;
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_push", last_push_cyc, saved);
        send_rx(8'h5A, 1'b1);
        drain("after_glitch");

        // Framing error discards the byte
        saved = last_push_cyc;
        send_rx(8'h12, 1'b0);
        repeat (20) @(negedge clk);
        check("framing_no_push", last_push_cyc, saved);
        check("framing_no_overrun", 32'(rx_overrun), 32'd0);

        // Backpressure: first byte held, second dropped
        bus.fifo_full = 1'b1;
        saved = last_push_cyc;
        send_rx(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        send_rx(8'h7E, 1'b1);
        repeat (20) @(negedge clk);
        check("held_while_full", last_push_cyc, saved);
        bus.fifo_full = 1'b0;
        repeat (10) @(negedge clk);
        check("held_byte_pushed", 32'(rx_exp.size()), 32'd0);
        check("overrun_flag", 32'(rx_overrun), 32'(exp_ovr()));

        // Back-to-back TX frames
        read_cyc.delete();
        tx_src.push_back(8'h55); tx_exp.push_back(8'h55);
        tx_src.push_back(8'h01); tx_exp.push_back(8'h01);
        drain("tx_pair");
        check("tx_pair_reads", 32'(read_cyc.size()), 32'd2);
        if (read_cyc.size() == 2)
            check("tx_frame_period", read_cyc[1] - read_cyc[0], 10 * C + 1);

        // Randomized concurrent RX and TX traffic
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_rx(8'($urandom), $urandom_range(0, 4) != 0);
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    tb_byte = 8'($urandom);
                    tx_src.push_back(tb_byte);
                    tx_exp.push_back(tb_byte);
                    repeat ($urandom_range(20, 150)) @(negedge clk);
                end
            end
        join
        drain("random");
        check("random_overrun_flag", 32'(rx_overrun), 32'(exp_ovr()));

        // Reset mid TX frame and mid RX frame
        read_cyc.delete();
        tx_src.push_back(8'hC3); tx_exp.push_back(8'hC3);
        for (int n = 0; n < 20 && read_cyc.size() == 0; n++) @(negedge clk);
        check("tx_c3_started", 32'(read_cyc.size()), 32'd1);
        uart_rx = 1'b0;
        saved = last_push_cyc;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_overrun = 1'b0;
        #1;
        check("midreset_uart_tx", 32'(uart_tx), 32'd1);
        check("midreset_tx_busy", 32'(tx_busy), 32'd0);
        check("midreset_overrun", 32'(rx_overrun), 32'd0);
        tx_src.push_back(8'h96); tx_exp.push_back(8'h96);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drain("after_reset");
        check("no_partial_rx_push", last_push_cyc, saved);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
